// File: rtl/peripheral_div.sv
// Bus-slave unsigned divider: restoring division, one quotient bit per clock.
// Software loads DIVIDEND/DIVISOR, writes CTRL.start, polls STATUS, reads results.
module peripheral_div #(
  parameter int DIV_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam int CNT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] dividend_q, dividend_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [31:0]      dout_q, dout_d;

  logic             wr_en, rd_en, busy, done, ge;
  logic [2:0]       sel;
  logic [DIV_W:0]   rem_sh, diff, quo_sh;
  logic [31:0]      rdata;
  logic             unused;

  assign wr_en = cs & wr;
  assign rd_en = cs & rd;
  assign sel   = addr[4:2];
  assign busy  = (state_q == BUSY);
  assign done  = (state_q == DONE);

  // Restoring step: shift the next dividend bit into the partial remainder,
  // then subtract the divisor when it fits (compare needs the extra top bit).
  assign rem_sh = {rem_q, quo_q[DIV_W-1]};
  assign diff   = rem_sh - {1'b0, divisor_q};
  assign ge     = (rem_sh >= {1'b0, divisor_q});
  assign quo_sh = {quo_q, ge};

  assign unused = ^{d_in, addr, diff[DIV_W], rem_sh[DIV_W], quo_sh[DIV_W]};

  always_comb begin
    rdata = 32'd0;
    case (sel)
      3'd0:    rdata = 32'(dividend_q);
      3'd1:    rdata = 32'(divisor_q);
      3'd3:    rdata = 32'(quo_q);
      3'd4:    rdata = 32'(rem_q);
      3'd5:    rdata = 32'({dz_q, done, busy});
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    dz_d       = dz_q;
    dout_d     = rd_en ? rdata : dout_q;

    if (busy) begin
      rem_d = ge ? diff[DIV_W-1:0] : rem_sh[DIV_W-1:0];
      quo_d = quo_sh[DIV_W-1:0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = DONE;
    end else if (wr_en) begin
      case (sel)
        3'd0: dividend_d = d_in[DIV_W-1:0];
        3'd1: divisor_d  = d_in[DIV_W-1:0];
        3'd2: begin
          if (d_in[0]) begin
            cnt_d = '0;
            if (divisor_q == '0) begin
              state_d = DONE;
              quo_d   = '1;
              rem_d   = dividend_q;
              dz_d    = 1'b1;
            end else begin
              state_d = BUSY;
              quo_d   = dividend_q;
              rem_d   = '0;
              dz_d    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      dz_q       <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      dz_q       <= dz_d;
      dout_q     <= dout_d;
    end
  end

  assign d_out = dout_q;

endmodule

// File: doc/peripheral_div.md
PERIPHERAL_DIV -- requirements
Module: peripheral_div

Interface
REQ-001 SHALL have parameter DIV_W, default 32, operand/result width in bits (legal 1..32).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port d_in  input  32  CPU write data.
REQ-005 SHALL have port cs  input  1  chip select from SOC address decoder.
REQ-006 SHALL have port addr  input  32  CPU byte address; only addr[4:2] decoded.
REQ-007 SHALL have port rd  input  1  read strobe, qualified by cs.
REQ-008 SHALL have port wr  input  1  write strobe, qualified by cs.
REQ-009 SHALL have port d_out  output  32  registered read data to SOC chip-select mux.

Function
REQ-010 SHALL implement an unsigned DIV_W-bit divider as a bus slave; accesses occur only when cs=1.
REQ-011 SHALL use this word map (addr[4:2]): 0 DIVIDEND R/W, 1 DIVISOR R/W, 2 CTRL W (bit0=start), 3 QUOTIENT R, 4 REMAINDER R, 5 STATUS R (bit0 busy, bit1 done, bit2 dz); 6-7 read 0, writes ignored.
REQ-012 SHALL capture d_in[DIV_W-1:0] into DIVIDEND/DIVISOR on the edge where cs&wr and FSM is not BUSY; writes during BUSY are dropped.
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL move IDLE or DONE -> BUSY on cs&wr to CTRL with d_in[0]=1 and DIVISOR!=0; clear done and dz; load remainder=0, quotient shift register=DIVIDEND, iteration counter=0.
REQ-015 SHALL perform one restoring-division step per cycle in BUSY: shift {rem,quo} left 1, subtract DIVISOR if rem>=DIVISOR (DIV_W+1-bit compare), set quotient LSB accordingly.
REQ-016 SHALL leave BUSY for DONE after exactly DIV_W steps; busy=0 and done=1 visible on the DIV_W-th edge after the start edge.
REQ-017 SHALL, on start with DIVISOR=0, go directly to DONE on the start edge with QUOTIENT=all-ones(DIV_W), REMAINDER=DIVIDEND, dz=1.
REQ-018 SHALL ignore start writes while BUSY (no restart, no flag change).
REQ-019 SHALL keep QUOTIENT/REMAINDER stable from DONE entry until the next accepted start; reads during BUSY return intermediate contents with no guarantee.
REQ-020 SHALL register d_out on edges where cs&rd: d_out = selected word zero-extended to 32 bits; 1-cycle read latency; d_out holds its value otherwise.
REQ-021 SHALL treat simultaneous cs&rd&wr as a write plus a read of the pre-write value.
REQ-022 SHALL ignore rd/wr when cs=0 (no state change, d_out held).
REQ-023 SHALL ignore CTRL bits other than bit0; writing start=0 has no effect.

Reset
REQ-024 SHALL, on resetn=0, asynchronously clear DIVIDEND, DIVISOR, QUOTIENT, REMAINDER, counter, d_out to 0, busy/done/dz to 0, FSM to IDLE.
REQ-025 SHALL abort any in-progress division on reset with no partial result retained.
REQ-026 SHALL require resetn deassertion synchronous to clk externally; first accepted access is the first edge after deassertion.

Verification
REQ-027 SHALL cover: DIVIDEND=100, DIVISOR=7, start -> busy=1 for 32 cycles, then STATUS=0x2, QUOTIENT=14, REMAINDER=2.
REQ-028 SHALL cover: 0xFFFFFFFF / 1 -> QUOTIENT=0xFFFFFFFF, REMAINDER=0; 5 / 9 -> QUOTIENT=0, REMAINDER=5.
REQ-029 SHALL cover: DIVISOR=0, DIVIDEND=0x1234, start -> next-cycle STATUS=0x6, QUOTIENT=0xFFFFFFFF, REMAINDER=0x1234.
REQ-030 SHALL cover: start 100/7, at cycle 10 write DIVISOR=3 and start again -> both ignored, result 14 r 2, DIVISOR reads 7.
REQ-031 SHALL cover: resetn low at cycle 16 of a division -> all registers 0, STATUS=0; a new 9/3 afterward yields 3 r 0.
REQ-032 SHALL cover: read STATUS with cs=0 -> d_out unchanged; read unmapped word 6 -> d_out=0.
